lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Initiator side of the data-memory port: accepts load/store requests from the pipeline MEM stage over a valid/ready handshake.
- Drives the memory's addr_mode/address/write-data port, which has combinational read and posedge write, and returns load data or a store acknowledge as a one-cycle response.
- Misaligned halfword/word accesses are split into byte-serial memory transactions, so the same master works with future word-banked memories or caches.
- Sits between the MEM-stage pipeline register and data memory.

Parameters:
- ADDR_WIDTH, 32, request/memory address width.
- DATA_WIDTH, 32, data width; only 32 supported.
- MISALIGN_SPLIT, 1, 1 = split misaligned accesses into byte accesses; 0 = flag them as errors.

Ports:
- clk  in  1  clock; everything samples on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  master can accept a request.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, LSB-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  invalid funct3, or misaligned access with MISALIGN_SPLIT=0.
- mem_addr_mode  out  4  memory op code (0000 LB, 0001 LH, 0010 LW, 0011 LBU, 0100 LHU, 0101 SB, 0110 SH, 0111 SW, 1111 IDLE).
- mem_addr  out  ADDR_WIDTH  memory byte address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, combinational from mem_addr/mem_addr_mode.

Behaviour:
- States: IDLE, ACCESS, SPLIT, RESP.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_addr_mode 1111, mem_addr 0, mem_wdata 0.
- Outside ACCESS/SPLIT, mem_addr_mode is 1111, so no memory write can occur.
- req_ready = (state==IDLE). A request is accepted on a posedge with req_valid && req_ready; the request is then registered.
- Alignment: halfword is misaligned if addr[0]=1; word is misaligned if addr[1:0]!=0; bytes are always aligned.
- IDLE -> RESP with resp_err=1 and no memory access if:
  - funct3 is invalid (load 011/110/111; store 011-111), or
  - the access is misaligned and MISALIGN_SPLIT=0.
- IDLE -> ACCESS for an aligned request.
  - mem_addr_mode = mapped code, mem_addr = addr, mem_wdata = wdata, held for exactly one cycle.
  - Loads: mem_rdata is captured at the end of the cycle, already extended by memory. Stores: memory commits at the end of the cycle.
  - ACCESS -> RESP.
- IDLE -> SPLIT for a misaligned request with MISALIGN_SPLIT=1.
  - Byte counter k = 0..N-1, with N = 2 (halfword) or 4 (word).
  - Each cycle: mem_addr = addr + k (ADDR_WIDTH wrap-around permitted).
  - Loads: mode LBU (0011); mem_rdata[7:0] is captured into byte lane k.
  - Stores: mode SB (0101); mem_wdata = wdata >> (8*k).
  - After k = N-1 -> RESP.
  - Assembled split load data is sign-extended (LH) or zero-extended (LHU) to 32 bits; LW uses all 4 lanes.
- RESP:
  - resp_valid = 1 for one cycle with resp_rdata/resp_err; stores give resp_rdata = 0.
  - RESP -> IDLE; the response has no backpressure.
- Latency (accept edge = edge 0):
  - aligned: resp_valid in cycle 2;
  - split halfword: cycle 3; split word: cycle 5;
  - error: cycle 1.
  - Throughput is 1 request per (latency+1) cycles.
- Request inputs are ignored while req_ready=0.
- rst in any state -> IDLE at that edge, with mem_addr_mode 1111 in the next cycle and no response.
  - Bytes already committed by a split store before reset stay in memory; partial stores are not rolled back.

Decomposition:
- lsu_pkg:
  - addr_mode localparams (LB..SW, IDLE=4'b1111);
  - funct3 localparams;
  - state enum {IDLE, ACCESS, SPLIT, RESP};
  - function mapping (is_store, funct3) -> addr_mode plus a valid flag.
- One sub-module, lsu_load_extend: combinational; inputs are the assembled 32-bit lanes and funct3; output is the extended result. It is used only on the SPLIT path.

Test Plan:
- Preload bytes 0x10000..0x10003 = 80 7F 12 34.
  - LB @0x10000 -> resp_rdata 0xFFFFFF80 in cycle 2.
  - LBU -> 0x00000080.
  - LW -> 0x34127F80; mem_addr_mode 0010 for exactly one cycle.
- SW 0xDEADBEEF @0x10001, split:
  - four SB cycles to addresses 0x10001..0x10004 with write bytes EF, BE, AD, DE;
  - resp_valid in cycle 5, resp_rdata 0;
  - a following split LW @0x10001 -> 0xDEADBEEF.
- Misaligned LH @0x10001 (bytes 7F 12): two LBU cycles -> resp_rdata 0x0000127F. With the byte at 0x10002 preset to 0x92 -> 0xFFFF927F.
- Load funct3=011 -> resp_err=1 and resp_valid in cycle 1, with mem_addr_mode staying 1111 throughout.
- MISALIGN_SPLIT=0 build, SW @0x10002 -> resp_err=1 and memory unchanged.
- rst asserted after the 2nd byte of a split SW:
  - state returns to IDLE, req_ready=1 the next cycle, no resp_valid;
  - only 0x10001 and 0x10002 are written.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory master.
//   - memory addr_mode codes driven on the data-memory port
//   - RISC-V load/store funct3 encodings
//   - master FSM state type
//   - map_mode(): (is_store, funct3) -> memory op code plus a valid flag
package lsu_pkg;

   localparam logic [3:0] AmLb   = 4'b0000;
   localparam logic [3:0] AmLh   = 4'b0001;
   localparam logic [3:0] AmLw   = 4'b0010;
   localparam logic [3:0] AmLbu  = 4'b0011;
   localparam logic [3:0] AmLhu  = 4'b0100;
   localparam logic [3:0] AmSb   = 4'b0101;
   localparam logic [3:0] AmSh   = 4'b0110;
   localparam logic [3:0] AmSw   = 4'b0111;
   localparam logic [3:0] AmIdle = 4'b1111;

   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   typedef enum logic [1:0] {StIdle, StAccess, StSplit, StResp} lsu_state_e;

   typedef struct packed {
      logic       valid;
      logic [3:0] mode;
   } mode_map_t;

   function automatic mode_map_t map_mode(input logic is_store, input logic [2:0] funct3);
      mode_map_t m;
      m.valid = 1'b1;
      m.mode  = AmIdle;
      if (is_store) begin
         case (funct3)
            F3Byte:  m.mode = AmSb;
            F3Half:  m.mode = AmSh;
            F3Word:  m.mode = AmSw;
            default: m.valid = 1'b0;
         endcase
      end else begin
         case (funct3)
            F3Byte:  m.mode = AmLb;
            F3Half:  m.mode = AmLh;
            F3Word:  m.mode = AmLw;
            F3ByteU: m.mode = AmLbu;
            F3HalfU: m.mode = AmLhu;
            default: m.valid = 1'b0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of byte-assembled load data (split path only).
//   lanes_i   assembled little-endian byte lanes
//   funct3_i  load funct3 of the request
//   result_o  extended 32-bit load result
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] lanes_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   always_comb begin
      result_o = lanes_i;
      case (funct3_i)
         F3Byte:  result_o = {{24{lanes_i[7]}}, lanes_i[7:0]};
         F3ByteU: result_o = {24'h0, lanes_i[7:0]};
         F3Half:  result_o = {{16{lanes_i[15]}}, lanes_i[15:0]};
         F3HalfU: result_o = {16'h0, lanes_i[15:0]};
         default: result_o = lanes_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Data-memory initiator for the MEM stage.
// Accepts load/store requests on a valid/ready handshake, drives the memory
// addr_mode/address/write-data port (combinational read, posedge write) and
// returns a one-cycle response. Misaligned halfword/word accesses are either
// split into byte-serial accesses (MISALIGN_SPLIT=1) or reported as errors.
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_is_store/funct3/addr/wdata request fields
//   resp_valid/resp_rdata/resp_err one-cycle response
//   mem_addr_mode/addr/wdata      memory command; mem_rdata read data
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32, // only 32 is supported
   parameter int unsigned MISALIGN_SPLIT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [3:0]            mem_addr_mode,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   lsu_state_e            state_q, state_d;
   logic                  is_store_q, is_store_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [3:0]            mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [1:0]            last_q, last_d;
   logic [31:0]           lanes_q, lanes_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   mode_map_t   map;
   logic        misaligned;
   logic [31:0] lanes_cur;
   logic [31:0] ext_result;

   assign map = map_mode(req_is_store, req_funct3);
   // funct3[1:0] is 01 for LH/LHU/SH and 10 for LW/SW
   assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

   // Lanes including the byte returned in the current split cycle, so the
   // final byte can be extended without an extra cycle.
   always_comb begin
      lanes_cur = lanes_q;
      lanes_cur[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
   end

   lsu_load_extend u_load_extend (
      .lanes_i  (lanes_cur),
      .funct3_i (funct3_q),
      .result_o (ext_result)
   );

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      funct3_d   = funct3_q;
      mode_d     = mode_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      lanes_d    = lanes_q;
      rdata_d    = rdata_q;
      err_d      = err_q;

      req_ready     = (state_q == StIdle);
      resp_valid    = 1'b0;
      resp_rdata    = '0;
      resp_err      = 1'b0;
      mem_addr_mode = AmIdle;
      mem_addr      = '0;
      mem_wdata     = '0;

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               is_store_d = req_is_store;
               funct3_d   = req_funct3;
               mode_d     = map.mode;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               cnt_d      = 2'd0;
               last_d     = (req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
               lanes_d    = '0;
               rdata_d    = '0;
               err_d      = 1'b0;
               if (!map.valid || (misaligned && (MISALIGN_SPLIT == 0))) begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end else if (misaligned) begin
                  state_d = StSplit;
               end else begin
                  state_d = StAccess;
               end
            end
         end
         StAccess: begin
            mem_addr_mode = mode_q;
            mem_addr      = addr_q;
            mem_wdata     = wdata_q;
            // memory already returns extended data for aligned loads
            if (!is_store_q) rdata_d = mem_rdata;
            state_d = StResp;
         end
         StSplit: begin
            mem_addr_mode = is_store_q ? AmSb : AmLbu;
            mem_addr      = addr_q + ADDR_WIDTH'(cnt_q);
            mem_wdata     = wdata_q >> {cnt_q, 3'b000};
            lanes_d       = lanes_cur;
            cnt_d         = cnt_q + 2'd1;
            if (cnt_q == last_q) begin
               if (!is_store_q) rdata_d = ext_result;
               state_d = StResp;
            end
         end
         StResp: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_err   = err_q;
            state_d    = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         is_store_q <= 1'b0;
         funct3_q   <= 3'b000;
         mode_q     <= AmIdle;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= 2'd0;
         last_q     <= 2'd0;
         lanes_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         funct3_q   <= funct3_d;
         mode_q     <= mode_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         lanes_q    <= lanes_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a byte-array data memory (window
// 0x10000..0x100FF) serves the split-capable instance; a second instance
// built with MISALIGN_SPLIT=0 has no memory and only its command is watched.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [3:0]  mem_addr_mode;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        ns_req_valid, ns_req_ready, ns_resp_valid, ns_resp_err;
   logic [31:0] ns_resp_rdata, ns_mem_addr, ns_mem_wdata;
   logic [3:0]  ns_mem_addr_mode;
   logic [31:0] ns_mem_rdata = 32'h0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MISALIGN_SPLIT(1)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr_mode(mem_addr_mode), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   lsu_mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MISALIGN_SPLIT(0)) u_dut_ns (
      .clk(clk), .rst(rst), .req_valid(ns_req_valid), .req_ready(ns_req_ready),
      .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata),
      .resp_err(ns_resp_err), .mem_addr_mode(ns_mem_addr_mode), .mem_addr(ns_mem_addr),
      .mem_wdata(ns_mem_wdata), .mem_rdata(ns_mem_rdata)
   );

   // Byte memory model, little-endian
   logic [7:0] mem [0:255];
   logic       bd_we = 1'b0;
   logic [7:0] bd_idx, bd_data;
   logic [7:0] i0, i1, i2, i3, b0, b1, b2, b3;

   always_comb begin
      i0 = mem_addr[7:0];
      i1 = i0 + 8'd1;
      i2 = i0 + 8'd2;
      i3 = i0 + 8'd3;
      b0 = mem[i0];
      b1 = mem[i1];
      b2 = mem[i2];
      b3 = mem[i3];
      case (mem_addr_mode)
         4'b0000: mem_rdata = {{24{b0[7]}}, b0};
         4'b0001: mem_rdata = {{16{b1[7]}}, b1, b0};
         4'b0010: mem_rdata = {b3, b2, b1, b0};
         4'b0011: mem_rdata = {24'h0, b0};
         4'b0100: mem_rdata = {16'h0, b1, b0};
         default: mem_rdata = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      case (mem_addr_mode)
         4'b0101: mem[i0] <= mem_wdata[7:0];
         4'b0110: begin
            mem[i0] <= mem_wdata[7:0];
            mem[i1] <= mem_wdata[15:8];
         end
         4'b0111: begin
            mem[i0] <= mem_wdata[7:0];
            mem[i1] <= mem_wdata[15:8];
            mem[i2] <= mem_wdata[23:16];
            mem[i3] <= mem_wdata[31:24];
         end
         default: ;
      endcase
   end

   // Results of the last run_req
   int          lat;
   logic [31:0] got_rdata;
   logic        got_err;
   logic [3:0]  lg_mode  [0:15];
   logic [31:0] lg_addr  [0:15];
   logic [31:0] lg_wdata [0:15];

   task automatic poke(input logic [7:0] idx, input logic [7:0] d);
      bd_we = 1'b1; bd_idx = idx; bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   // Issues one request, logs the memory command per cycle (cycle 1 follows
   // the accept edge) and returns in IDLE. With noise set, an invalid request
   // is held on the inputs while the master is busy.
   task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit noise);
      lat = -1; got_rdata = 32'hx; got_err = 1'bx;
      req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk); #1;
      if (noise) begin
         req_is_store = 1'b1; req_funct3 = 3'b011; req_addr = 32'h10003; req_wdata = 32'h0;
      end else begin
         req_valid = 1'b0;
      end
      for (int c = 1; c < 16; c++) begin
         lg_mode[c] = mem_addr_mode; lg_addr[c] = mem_addr; lg_wdata[c] = mem_wdata;
         if (resp_valid) begin
            lat = c; got_rdata = resp_rdata; got_err = resp_err;
            req_valid = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; ns_req_valid = 1'b0;
      req_is_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", resp_err); end
      checks++; if (mem_addr_mode !== 4'hF) begin failures++; $display("FAIL rst_mode got=%h exp=f", mem_addr_mode); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
      checks++; if (ns_req_ready !== 1'b1 || ns_mem_addr !== 32'h0 || ns_mem_wdata !== 32'h0)
         begin failures++; $display("FAIL rst_ns got=%b/%h/%h exp=1/0/0", ns_req_ready, ns_mem_addr, ns_mem_wdata); end
   endtask

   task automatic test_aligned();
      poke(8'h00, 8'h80); poke(8'h01, 8'h7F); poke(8'h02, 8'h12); poke(8'h03, 8'h34);
      run_req(1'b0, 3'b000, 32'h10000, 32'h0, 1'b0);  // LB
      checks++; if (lat !== 2) begin failures++; $display("FAIL lb_lat got=%0d exp=2", lat); end
      checks++; if (got_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", got_rdata); end
      checks++; if (lg_mode[1] !== 4'h0 || lg_addr[1] !== 32'h10000)
         begin failures++; $display("FAIL lb_cmd got=%h@%h exp=0@10000", lg_mode[1], lg_addr[1]); end
      run_req(1'b0, 3'b100, 32'h10000, 32'h0, 1'b0);  // LBU
      checks++; if (got_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", got_rdata); end
      run_req(1'b0, 3'b010, 32'h10000, 32'h0, 1'b0);  // LW
      checks++; if (got_rdata !== 32'h34127F80 || got_err !== 1'b0)
         begin failures++; $display("FAIL lw_data got=%h/%b exp=34127f80/0", got_rdata, got_err); end
      checks++; if (lg_mode[1] !== 4'h2 || lg_mode[2] !== 4'hF)
         begin failures++; $display("FAIL lw_mode got=%h,%h exp=2,f", lg_mode[1], lg_mode[2]); end
      run_req(1'b0, 3'b001, 32'h10002, 32'h0, 1'b0);  // LH
      checks++; if (got_rdata !== 32'h00003412 || lat !== 2)
         begin failures++; $display("FAIL lh_al got=%h lat=%0d exp=00003412 lat=2", got_rdata, lat); end
      run_req(1'b1, 3'b010, 32'h10008, 32'h11223344, 1'b0);  // aligned SW
      checks++; if (lat !== 2 || got_rdata !== 32'h0 || lg_mode[1] !== 4'h7)
         begin failures++; $display("FAIL sw_al got lat=%0d data=%h mode=%h exp lat=2 data=0 mode=7", lat, got_rdata, lg_mode[1]); end
      checks++; if ({mem[11], mem[10], mem[9], mem[8]} !== 32'h11223344)
         begin failures++; $display("FAIL sw_al_mem got=%h exp=11223344", {mem[11], mem[10], mem[9], mem[8]}); end
   endtask

   task automatic test_split_store();
      logic [7:0] eb [0:3];
      eb[0] = 8'hEF; eb[1] = 8'hBE; eb[2] = 8'hAD; eb[3] = 8'hDE;
      run_req(1'b1, 3'b010, 32'h10001, 32'hDEADBEEF, 1'b0);
      checks++; if (lat !== 5 || got_rdata !== 32'h0 || got_err !== 1'b0)
         begin failures++; $display("FAIL ssw_resp got lat=%0d data=%h err=%b exp lat=5 data=0 err=0", lat, got_rdata, got_err); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (lg_mode[k+1] !== 4'h5 || lg_addr[k+1] !== 32'h10001 + k || lg_wdata[k+1][7:0] !== eb[k]) begin
            failures++;
            $display("FAIL ssw_byte%0d got %h@%h=%h exp 5@%h=%h", k, lg_mode[k+1], lg_addr[k+1],
                     lg_wdata[k+1][7:0], 32'h10001 + k, eb[k]);
         end
      end
      checks++; if ({mem[4], mem[3], mem[2], mem[1]} !== 32'hDEADBEEF)
         begin failures++; $display("FAIL ssw_mem got=%h exp=deadbeef", {mem[4], mem[3], mem[2], mem[1]}); end
      run_req(1'b0, 3'b010, 32'h10001, 32'h0, 1'b1);  // split LW, busy-time noise
      checks++; if (lat !== 5 || got_rdata !== 32'hDEADBEEF || got_err !== 1'b0)
         begin failures++; $display("FAIL slw got lat=%0d data=%h err=%b exp lat=5 data=deadbeef err=0", lat, got_rdata, got_err); end
      checks++; if (lg_mode[1] !== 4'h3 || lg_mode[4] !== 4'h3 || lg_addr[4] !== 32'h10004)
         begin failures++; $display("FAIL slw_cmd got %h,%h@%h exp 3,3@10004", lg_mode[1], lg_mode[4], lg_addr[4]); end
   endtask

   task automatic test_split_half();
      poke(8'h01, 8'h7F); poke(8'h02, 8'h12);
      run_req(1'b0, 3'b001, 32'h10001, 32'h0, 1'b0);
      checks++; if (lat !== 3 || got_rdata !== 32'h0000127F)
         begin failures++; $display("FAIL slh got lat=%0d data=%h exp lat=3 data=0000127f", lat, got_rdata); end
      checks++; if (lg_mode[1] !== 4'h3 || lg_mode[2] !== 4'h3 || lg_addr[2] !== 32'h10002)
         begin failures++; $display("FAIL slh_cmd got %h,%h@%h exp 3,3@10002", lg_mode[1], lg_mode[2], lg_addr[2]); end
      poke(8'h02, 8'h92);
      run_req(1'b0, 3'b001, 32'h10001, 32'h0, 1'b0);
      checks++; if (got_rdata !== 32'hFFFF927F) begin failures++; $display("FAIL slh_neg got=%h exp=ffff927f", got_rdata); end
      run_req(1'b0, 3'b101, 32'h10001, 32'h0, 1'b0);
      checks++; if (got_rdata !== 32'h0000927F) begin failures++; $display("FAIL slhu got=%h exp=0000927f", got_rdata); end
      run_req(1'b1, 3'b001, 32'h10003, 32'h0000ABCD, 1'b0);
      checks++; if (lat !== 3 || mem[3] !== 8'hCD || mem[4] !== 8'hAB)
         begin failures++; $display("FAIL ssh got lat=%0d mem=%h%h exp lat=3 mem=abcd", lat, mem[4], mem[3]); end
   endtask

   task automatic test_error();
      run_req(1'b0, 3'b011, 32'h10000, 32'h0, 1'b0);
      checks++; if (lat !== 1 || got_err !== 1'b1 || got_rdata !== 32'h0)
         begin failures++; $display("FAIL err_ld got lat=%0d err=%b data=%h exp lat=1 err=1 data=0", lat, got_err, got_rdata); end
      checks++; if (lg_mode[1] !== 4'hF) begin failures++; $display("FAIL err_ld_mode got=%h exp=f", lg_mode[1]); end
      run_req(1'b1, 3'b100, 32'h10000, 32'h0, 1'b0);
      checks++; if (lat !== 1 || got_err !== 1'b1)
         begin failures++; $display("FAIL err_st got lat=%0d err=%b exp lat=1 err=1", lat, got_err); end
   endtask

   task automatic test_nosplit();
      int ns_lat = -1;
      int ns_cmds = 0;
      logic ns_err = 1'b0;
      req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10002; req_wdata = 32'h55555555;
      ns_req_valid = 1'b1;
      @(posedge clk); #1;
      ns_req_valid = 1'b0;
      for (int c = 1; c < 8; c++) begin
         if (ns_mem_addr_mode !== 4'hF) ns_cmds++;
         if (ns_resp_valid && ns_lat < 0) begin ns_lat = c; ns_err = ns_resp_err; end
         @(posedge clk); #1;
      end
      checks++; if (ns_lat !== 1 || ns_err !== 1'b1)
         begin failures++; $display("FAIL ns_err got lat=%0d err=%b exp lat=1 err=1", ns_lat, ns_err); end
      checks++; if (ns_cmds !== 0) begin failures++; $display("FAIL ns_nomem got=%0d exp=0", ns_cmds); end
   endtask

   task automatic test_reset_mid();
      int resp_seen = 0;
      poke(8'h01, 8'h00); poke(8'h02, 8'h00); poke(8'h03, 8'h00); poke(8'h04, 8'h00);
      req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10001; req_wdata = 32'hA1B2C3D4;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (mem_addr_mode !== 4'h5 || mem_addr !== 32'h10001)
         begin failures++; $display("FAIL rm_b0 got %h@%h exp 5@10001", mem_addr_mode, mem_addr); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (req_ready !== 1'b1 || mem_addr_mode !== 4'hF || resp_valid !== 1'b0)
         begin failures++; $display("FAIL rm_idle got rdy=%b mode=%h rv=%b exp 1/f/0", req_ready, mem_addr_mode, resp_valid); end
      for (int c = 0; c < 6; c++) begin
         if (resp_valid) resp_seen++;
         @(posedge clk); #1;
      end
      checks++; if (resp_seen !== 0) begin failures++; $display("FAIL rm_noresp got=%0d exp=0", resp_seen); end
      checks++; if ({mem[4], mem[3], mem[2], mem[1]} !== 32'h0000C3D4)
         begin failures++; $display("FAIL rm_mem got=%h exp=0000c3d4", {mem[4], mem[3], mem[2], mem[1]}); end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_split_store();
      test_split_half();
      test_error();
      test_nosplit();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
